// File: rtl/wdog_pkg.sv
// Shared watchdog definitions: register map, key/data values, FSM state and sequence encodings.
// The register block uses the same package, so the sequencer and the registers agree on the map.
package wdog_pkg;

    localparam int unsigned CNT_W = 32;

    localparam logic [3:0] ADDR_IDLE  = 4'h0;
    localparam logic [3:0] ADDR_CTRL  = 4'h1;
    localparam logic [3:0] ADDR_KICK  = 4'h2;
    localparam logic [3:0] ADDR_STAT  = 4'hA;
    localparam logic [3:0] ADDR_KSTAT = 4'hE;
    localparam logic [3:0] ADDR_LOCK  = 4'hF;

    localparam logic [31:0] DATA_CTRL_EN = 32'h0000_0001;
    localparam logic [31:0] DATA_LOCK    = 32'h0000_000F;
    localparam logic [31:0] KEY_KICK_A   = 32'h0000_00AA;
    localparam logic [31:0] KEY_KICK_B   = 32'h0000_0055;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR1  = 3'd1,
        ST_RD   = 3'd2,
        ST_RCHK = 3'd3,
        ST_WR3  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEQ_ENABLE  = 2'd0,
        SEQ_DISABLE = 2'd1,
        SEQ_KICK    = 2'd2
    } seq_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } bus_op_t;

    // Bus operation issued by a given sequence in a given state; idle states map to a zero op.
    function automatic bus_op_t seq_op(input seq_t seq, input state_t st);
        bus_op_t op;
        op = '{addr: ADDR_IDLE, data: 32'h0};
        case (seq)
            SEQ_ENABLE: begin
                if (st == ST_WR1) op = '{addr: ADDR_CTRL, data: DATA_CTRL_EN};
                if (st == ST_RD)  op.addr = ADDR_STAT;
                if (st == ST_WR3) op = '{addr: ADDR_LOCK, data: DATA_LOCK};
            end
            SEQ_DISABLE: begin
                if (st == ST_WR1) op = '{addr: ADDR_LOCK, data: DATA_LOCK};
                if (st == ST_RD)  op.addr = ADDR_STAT;
                if (st == ST_WR3) op = '{addr: ADDR_CTRL, data: DATA_CTRL_EN};
            end
            SEQ_KICK: begin
                if (st == ST_WR1) op = '{addr: ADDR_KICK, data: KEY_KICK_A};
                if (st == ST_RD)  op.addr = ADDR_KSTAT;
                if (st == ST_WR3) op = '{addr: ADDR_KICK, data: KEY_KICK_B};
            end
            default: op = '{addr: ADDR_IDLE, data: 32'h0};
        endcase
        return op;
    endfunction

    // A request coinciding with the clear of an already-set flag survives; one consumed directly does not.
    function automatic logic pend_upd(input logic pend, input logic req, input logic clr);
        return clr ? (pend & req) : (pend | req);
    endfunction

endpackage

// File: rtl/wdog_kick_timer.sv
// Auto-kick down-counter: reloads on demand, counts while running, and flags a kick at zero.
// It saturates at zero so a stalled kick cannot wrap into a long silent interval.
module wdog_kick_timer
    import wdog_pkg::*;
#(
    parameter logic [CNT_W-1:0] KICK_PERIOD = 32'd1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic fire
);

    localparam logic [CNT_W-1:0] RELOAD = KICK_PERIOD - 32'd1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 32'd1;
        end
    end

    assign fire = run && (cnt == '0);

endmodule

// File: rtl/wdog_seq_master.sv
// Watchdog sequencer: arbitrates enable/disable/kick requests and drives write-read-write
// register sequences, checking the acknowledge token returned by the read.
//
// state | meaning
// IDLE  | no sequence; arbitrate or reject pending requests
// WR1   | first write of the selected sequence
// RD    | read strobe
// RCHK  | RDATA compared with the acknowledge token
// WR3   | final write (only after a good token)
// FIN   | DONE or ERR pulse; ARMED and the kick timer update here
module wdog_seq_master
    import wdog_pkg::*;
#(
    parameter logic [31:0] KICK_PERIOD = 32'd1000,
    parameter logic [31:0] ACK_TOKEN   = 32'h0000_A5A5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_enable,
    input  logic        req_disable,
    input  logic        req_kick,
    input  logic        auto_kick,
    input  logic [31:0] rdata,
    output logic        write,
    output logic        read,
    output logic [3:0]  addr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        armed
);

    state_t  state, state_nxt;
    seq_t    seq, seq_nxt;
    bus_op_t op;
    logic    fail, err_rej, rej;
    logic    pend_en, pend_dis, pend_kick;
    logic    clr_en, clr_dis, clr_kick;
    logic    eff_en, eff_dis, eff_kick;
    logic    kick_fire, timer_load;

    assign eff_en   = pend_en   | req_enable;
    assign eff_dis  = pend_dis  | req_disable;
    assign eff_kick = pend_kick | req_kick | kick_fire;

    assign timer_load = (state == ST_FIN) &&
                        ((seq == SEQ_KICK) || (!fail && (seq == SEQ_ENABLE)));

    wdog_kick_timer #(.KICK_PERIOD(KICK_PERIOD)) u_kick_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .run   (armed && auto_kick && (state == ST_IDLE)),
        .fire  (kick_fire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            seq       <= SEQ_ENABLE;
            fail      <= 1'b0;
            err_rej   <= 1'b0;
            armed     <= 1'b0;
            pend_en   <= 1'b0;
            pend_dis  <= 1'b0;
            pend_kick <= 1'b0;
        end else begin
            state     <= state_nxt;
            seq       <= seq_nxt;
            err_rej   <= rej;
            pend_en   <= pend_upd(pend_en, req_enable, clr_en);
            pend_dis  <= pend_upd(pend_dis, req_disable, clr_dis);
            pend_kick <= pend_upd(pend_kick, req_kick | kick_fire, clr_kick);
            if (state == ST_RCHK) fail <= (rdata != ACK_TOKEN);
            if ((state == ST_FIN) && !fail) begin
                if (seq == SEQ_ENABLE)  armed <= 1'b1;
                if (seq == SEQ_DISABLE) armed <= 1'b0;
            end
        end
    end

    // One request is resolved per idle cycle: the winner either starts or is rejected.
    always_comb begin
        state_nxt = state;
        seq_nxt   = seq;
        clr_en    = 1'b0;
        clr_dis   = 1'b0;
        clr_kick  = 1'b0;
        rej       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (eff_dis) begin
                    clr_dis = 1'b1;
                    if (armed) begin
                        state_nxt = ST_WR1;
                        seq_nxt   = SEQ_DISABLE;
                    end else begin
                        rej = 1'b1;
                    end
                end else if (eff_kick) begin
                    clr_kick = 1'b1;
                    if (armed) begin
                        state_nxt = ST_WR1;
                        seq_nxt   = SEQ_KICK;
                    end else begin
                        rej = 1'b1;
                    end
                end else if (eff_en) begin
                    clr_en = 1'b1;
                    if (!armed) begin
                        state_nxt = ST_WR1;
                        seq_nxt   = SEQ_ENABLE;
                    end else begin
                        rej = 1'b1;
                    end
                end
            end
            ST_WR1:  state_nxt = ST_RD;
            ST_RD:   state_nxt = ST_RCHK;
            ST_RCHK: state_nxt = (rdata == ACK_TOKEN) ? ST_WR3 : ST_FIN;
            ST_WR3:  state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        op    = seq_op(seq, state);
        write = (state == ST_WR1) || (state == ST_WR3);
        read  = (state == ST_RD);
        addr  = (write || read) ? op.addr : ADDR_IDLE;
        wdata = write ? op.data : 32'h0;
        busy  = (state != ST_IDLE);
        done  = (state == ST_FIN) && !fail;
        err   = ((state == ST_FIN) && fail) || err_rej;
    end

endmodule

// File: tb/tb_wdog_seq_master.sv
// Bench for wdog_seq_master: a request-level model predicts timed bus events into a
// scoreboard queue that an independent monitor drains as the DUT produces them.
module tb_wdog_seq_master;

    localparam logic [31:0] KP  = 32'd8;
    localparam logic [31:0] ACK = 32'h0000_A5A5;
    localparam int K_WR = 0, K_RD = 1, K_DONE = 2, K_ERR = 3;
    localparam int S_EN = 0, S_DIS = 1, S_KICK = 2;

    logic        clk, rst_n;
    logic        req_enable, req_disable, req_kick, auto_kick;
    logic [31:0] rdata;
    logic        write, read, busy, done, err, armed;
    logic [3:0]  addr;
    logic [31:0] wdata;

    wdog_seq_master #(.KICK_PERIOD(KP), .ACK_TOKEN(ACK)) dut (
        .clk(clk), .rst_n(rst_n), .req_enable(req_enable), .req_disable(req_disable),
        .req_kick(req_kick), .auto_kick(auto_kick), .rdata(rdata), .write(write),
        .read(read), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .err(err), .armed(armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [3:0]  addr;
        logic [31:0] data;
    } evt_t;

    evt_t        exp_q[$];
    logic [31:0] tok_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          m_armed = 1'b0;
    bit          read_d = 1'b0;

    // Register map of each sequence, indexed by S_EN / S_DIS / S_KICK.
    logic [3:0]  wr1_a [3] = '{4'h1, 4'hF, 4'h2};
    logic [31:0] wr1_d [3] = '{32'h01, 32'h0F, 32'hAA};
    logic [3:0]  rd_a  [3] = '{4'hA, 4'hA, 4'hE};
    logic [3:0]  wr3_a [3] = '{4'hF, 4'h1, 4'h2};
    logic [31:0] wr3_d [3] = '{32'h0F, 32'h01, 32'h55};

    function automatic void push_evt(int c, int k, logic [3:0] a, logic [31:0] d);
        evt_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic logic [31:0] bad_tok();
        logic [31:0] b;
        b = $urandom;
        if (b == ACK) b = ~b;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Request resolved in idle cycle n; returns the cycle of its last output event.
    task automatic model_seq(input int k, input int n, input bit match, output int last);
        bit ok;
        ok = (k == S_EN) ? !m_armed : m_armed;
        if (!ok) begin
            push_evt(n + 1, K_ERR, 4'h0, 32'h0);
            last = n + 1;
        end else begin
            push_evt(n + 1, K_WR, wr1_a[k], wr1_d[k]);
            push_evt(n + 2, K_RD, rd_a[k], 32'h0);
            tok_q.push_back(match ? ACK : bad_tok());
            if (match) begin
                push_evt(n + 4, K_WR, wr3_a[k], wr3_d[k]);
                push_evt(n + 5, K_DONE, 4'h0, 32'h0);
                last = n + 5;
                if (k == S_EN)  m_armed = 1'b1;
                if (k == S_DIS) m_armed = 1'b0;
            end else begin
                push_evt(n + 4, K_ERR, 4'h0, 32'h0);
                last = n + 4;
            end
        end
    endtask

    task automatic chk_evt(input int k, input logic [3:0] a, input logic [31:0] d);
        evt_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_evt: got kind %0d addr %h data %h at cycle %0d, expected no event",
                     k, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.addr !== a || e.data !== d) begin
                miscompares++;
                $display("FAIL bus_evt: got kind %0d cyc %0d addr %h data %h, expected kind %0d cyc %0d addr %h data %h",
                         k, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (write) chk_evt(K_WR, addr, wdata);
            if (read)  chk_evt(K_RD, addr, 32'h0);
            if (done)  chk_evt(K_DONE, 4'h0, 32'h0);
            if (err)   chk_evt(K_ERR, 4'h0, 32'h0);
            if (!write) check("wdata_idle", wdata, 32'h0);
            if (!write && !read) check("addr_idle", {28'h0, addr}, 32'h0);
        end
    end

    // Register-block stand-in: answers each read with the next queued token one cycle later.
    always @(posedge clk) begin
        #1;
        if (read_d && tok_q.size() > 0) rdata = tok_q.pop_front();
        else rdata = $urandom;
        read_d = read;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic set_req(input int k, input logic v);
        if (k == S_EN)   req_enable  = v;
        if (k == S_DIS)  req_disable = v;
        if (k == S_KICK) req_kick    = v;
    endtask

    task automatic issue(input int k, input bit m);
        int n, last;
        n = cyc;
        set_req(k, 1'b1);
        model_seq(k, n, m, last);
        tick();
        set_req(k, 1'b0);
        wait_until(last + 2);
    endtask

    task automatic ensure_armed(input bit want);
        if (m_armed != want) issue(want ? S_EN : S_DIS, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write"}, {31'h0, write}, 32'h0);
        check({tag, "_read"},  {31'h0, read},  32'h0);
        check({tag, "_busy"},  {31'h0, busy},  32'h0);
        check({tag, "_done"},  {31'h0, done},  32'h0);
        check({tag, "_err"},   {31'h0, err},   32'h0);
        check({tag, "_armed"}, {31'h0, armed}, 32'h0);
        check({tag, "_addr"},  {28'h0, addr},  32'h0);
        check({tag, "_wdata"}, wdata, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n, last, l1, l2, l3;
        bit m;
        rst_n = 1'b0; req_enable = 1'b0; req_disable = 1'b0; req_kick = 1'b0;
        auto_kick = 1'b0; rdata = 32'h0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        issue(S_EN, 1'b1);
        check("armed_after_enable", {31'h0, armed}, 32'h1);
        issue(S_KICK, 1'b0);
        check("armed_after_bad_kick", {31'h0, armed}, 32'h1);
        ensure_armed(1'b0);
        issue(S_KICK, 1'b1);

        repeat (20) begin
            issue($urandom_range(0, 2), $urandom_range(0, 3) != 0);
            check("armed_model", {31'h0, armed}, {31'h0, m_armed});
        end

        // Periodic kicks: each starts 8 idle cycles after the previous FIN.
        ensure_armed(1'b0);
        auto_kick = 1'b1;
        n = cyc;
        req_enable = 1'b1;
        model_seq(S_EN, n, 1'b1, last);
        for (int i = 0; i < 3; i++) model_seq(S_KICK, last + 8, $urandom_range(0, 1) == 1, last);
        tick();
        req_enable = 1'b0;
        wait_until(last + 1);
        auto_kick = 1'b0;
        wait_until(last + 20);
        check("armed_after_autokick", {31'h0, armed}, 32'h1);

        // Simultaneous disable and kick: disable wins, the held kick is then rejected.
        n = cyc;
        req_disable = 1'b1;
        req_kick = 1'b1;
        model_seq(S_DIS, n, 1'b1, l1);
        model_seq(S_KICK, l1 + 1, 1'b1, l2);
        tick();
        req_disable = 1'b0;
        req_kick = 1'b0;
        wait_until(l2 + 2);
        check("armed_after_disable", {31'h0, armed}, 32'h0);

        // Kick held while enable runs, plus a repeat arriving as that flag clears.
        n = cyc;
        req_enable = 1'b1;
        model_seq(S_EN, n, 1'b1, l1);
        tick();
        req_enable = 1'b0;
        wait_until(n + 2);
        req_kick = 1'b1;
        tick();
        req_kick = 1'b0;
        wait_until(l1 + 1);
        req_kick = 1'b1;
        m = $urandom_range(0, 1) == 1;
        model_seq(S_KICK, l1 + 1, m, l2);
        model_seq(S_KICK, l2 + 1, 1'b1, l3);
        tick();
        req_kick = 1'b0;
        wait_until(l3 + 3);

        // Reset during the read of a disable sequence.
        ensure_armed(1'b1);
        n = cyc;
        req_disable = 1'b1;
        push_evt(n + 1, K_WR, 4'hF, 32'h0F);
        tick();
        req_disable = 1'b0;
        wait_until(n + 2);
        check("read_before_reset", {31'h0, read}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        m_armed = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("idle_busy", {31'h0, busy}, 32'h0);
        check("idle_armed", {31'h0, armed}, 32'h0);

        check("exp_queue_left", exp_q.size(), 32'h0);
        check("tok_queue_left", tok_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
